// File: rtl/boid_pkg.sv
// boid_pkg: constants and types shared by the boid frame scheduler and the
// BPUs that compute pixel addresses.
package boid_pkg;

  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = 19;
  localparam int MAX_BOIDS           = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    WRITE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/pixel_addr_calc.sv
// pixel_addr_calc: combinational (x, y) -> linear pixel address for a
// 640-pixel line, built from shifts and adds: y*640 = (y<<9) + (y<<7).
// Also reports whether (x, y) lies inside the visible frame.
// Ports:
//   x         in  10  pixel column
//   y         in   9  pixel row
//   addr      out ADDR_W  linear address, truncated to ADDR_W bits
//   in_bounds out  1  x < X_LIMIT and y < Y_LIMIT
module pixel_addr_calc
  import boid_pkg::*;
#(
  parameter int ADDR_W  = PIXEL_ADDRESS_WIDTH,
  parameter int X_LIMIT = VIDEO_WIDTH,
  parameter int Y_LIMIT = VIDEO_HEIGHT
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  localparam logic [10:0] X_LIM = 11'(X_LIMIT);
  localparam logic [9:0]  Y_LIM = 10'(Y_LIMIT);

  // 20 bits holds the worst case 511*640 + 1023 without overflow.
  logic [19:0] sum;

  assign sum       = {2'b00, y, 9'b0} + {4'b0000, y, 7'b0} + {10'b0, x};
  assign addr      = ADDR_W'(sum);
  assign in_bounds = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);

endmodule

// File: rtl/boid_frame_scheduler.sv
// boid_frame_scheduler: on each end-of-screen strobe, clears the display
// RAM, then scans every BPU and writes one pixel per boid.
// Optional build macro: BOID_SCHED_BOUNDS_CHECK_EN (suppresses writes for
// off-screen boids and counts them on skip_count).
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   screen_end       end-of-frame strobe from the VGA controller
//   boid_sel         BPU index driving the x/y mux
//   boid_x, boid_y   coordinates of the selected boid
//   disp_clear       one-cycle display RAM clear
//   disp_we          display RAM write enable (data implicitly 1)
//   disp_addr        display RAM write address
//   busy             frame rebuild in progress
//   frame_done       one-cycle pulse after the last write
//   overrun          sticky: a frame strobe was dropped
//   skip_count       (macro only) saturating count of skipped boids
module boid_frame_scheduler
  import boid_pkg::*;
#(
  parameter int MAX_BOIDS           = boid_pkg::MAX_BOIDS,
  parameter int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS),
  parameter int VIDEO_WIDTH         = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT        = boid_pkg::VIDEO_HEIGHT,
  parameter int PIXEL_ADDRESS_WIDTH = boid_pkg::PIXEL_ADDRESS_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           screen_end,
  output logic [BITS_FOR_BOIDS-1:0]      boid_sel,
  input  logic [9:0]                     boid_x,
  input  logic [8:0]                     boid_y,
  output logic                           disp_clear,
  output logic                           disp_we,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] disp_addr,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
  ,
  output logic [7:0]                     skip_count
`endif
);

`ifdef BOID_SCHED_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_SEL = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  sched_state_t                   state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0]      sel_q, sel_d;
  logic [9:0]                     x_r_q, x_r_d;
  logic [8:0]                     y_r_q, y_r_d;
  logic                           pending_q, pending_d;
  logic                           overrun_q, overrun_d;
  logic                           clear_q, clear_d;
  logic                           we_q, we_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
  logic [7:0]                     skip_q, skip_d;
`endif

  logic [PIXEL_ADDRESS_WIDTH-1:0] calc_addr;
  logic                           calc_in_bounds;

  // Fed from the x_r/y_r next-state so the address is registered together
  // with the coordinates, landing on disp_addr in the WRITE cycle.
  pixel_addr_calc #(
    .ADDR_W  (PIXEL_ADDRESS_WIDTH),
    .X_LIMIT (VIDEO_WIDTH),
    .Y_LIMIT (VIDEO_HEIGHT)
  ) u_addr (
    .x         (x_r_d),
    .y         (y_r_d),
    .addr      (calc_addr),
    .in_bounds (calc_in_bounds)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    x_r_d     = x_r_q;
    y_r_d     = y_r_q;
    pending_d = pending_q;
    overrun_d = overrun_q | (screen_end & pending_q);
    addr_d    = addr_q;
    we_d      = 1'b0;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
    skip_d    = skip_q;
`endif

    if (screen_end && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (screen_end || pending_q) begin
          state_d   = CLEAR;
          pending_d = 1'b0;
        end
      end
      CLEAR: begin
        sel_d   = '0;
        state_d = FETCH;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
        skip_d  = 8'd0;
`endif
      end
      FETCH: begin
        x_r_d   = boid_x;
        y_r_d   = boid_y;
        addr_d  = calc_addr;
        we_d    = calc_in_bounds || !BOUNDS_EN;
        state_d = WRITE;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
        if (!calc_in_bounds && (skip_q != 8'hFF)) skip_d = skip_q + 8'd1;
`endif
      end
      WRITE: begin
        if (sel_q == LAST_SEL) begin
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state so they align with it.
    clear_d = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      x_r_q     <= '0;
      y_r_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      clear_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
      skip_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      x_r_q     <= x_r_d;
      y_r_q     <= y_r_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      clear_q   <= clear_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign boid_sel   = sel_q;
  assign disp_clear = clear_q;
  assign disp_we    = we_q;
  assign disp_addr  = addr_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
  assign skip_count = skip_q;
`endif

endmodule

// File: tb/tb_boid_frame_scheduler.sv
module tb_boid_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        screen_end;
  logic [1:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        disp_clear;
  logic        disp_we;
  logic [18:0] disp_addr;
  logic        busy;
  logic        frame_done;
  logic        overrun;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
  logic [7:0]  skip_count;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [9:0] bx [4];
  logic [8:0] by [4];
  int         exp_addr [4];

  always #5 clock = ~clock;

  // BPU output mux model
  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .screen_end (screen_end),
    .boid_sel   (boid_sel),
    .boid_x     (boid_x),
    .boid_y     (boid_y),
    .disp_clear (disp_clear),
    .disp_we    (disp_we),
    .disp_addr  (disp_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
    ,
    .skip_count (skip_count)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (k=%0d): got %0d expected %0d", tag, k, obs, expv);
    end
  endtask

  // Walks cycles N+1..N+11 after a strobe seen at cycle N. Strobes are
  // raised during cycles N+se1 / N+se2 (0 = none).
  task automatic run_frame(input int se1, input int se2, input logic [3:0] mask,
                           input logic exp_ovr);
    for (int k = 1; k <= 11; k++) begin
      step();
      screen_end = (k == se1) || (k == se2);
      chk("clear", k, int'(disp_clear), (k == 1) ? 1 : 0);
      chk("done",  k, int'(frame_done), (k == 10) ? 1 : 0);
      chk("busy",  k, int'(busy),       (k <= 10) ? 1 : 0);
      if ((k >= 3) && (k <= 9) && (k % 2 == 1)) begin
        chk("we",  k, int'(disp_we), int'(mask[(k - 3) / 2]));
        chk("sel", k, int'(boid_sel), (k - 3) / 2);
        if (mask[(k - 3) / 2]) chk("addr", k, int'(disp_addr), exp_addr[(k - 3) / 2]);
      end else begin
        chk("we",  k, int'(disp_we), 0);
      end
      if ((k >= 2) && (k <= 8) && (k % 2 == 0)) chk("sel", k, int'(boid_sel), (k - 2) / 2);
    end
    screen_end = 1'b0;
    chk("overrun", 11, int'(overrun), int'(exp_ovr));
  endtask

  task automatic idle_check(input int n, input logic exp_ovr);
    int acts;
    acts = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (disp_clear || disp_we || busy) acts++;
    end
    chk("idle_activity", n, acts, 0);
    chk("idle_overrun", n, int'(overrun), int'(exp_ovr));
  endtask

  initial begin
    logic [3:0] mask_b;
    int writes;
    reset      = 1'b1;
    screen_end = 1'b0;
    bx[0] = 10'd0;   by[0] = 9'd0;
    bx[1] = 10'd1;   by[1] = 9'd0;
    bx[2] = 10'd0;   by[2] = 9'd1;
    bx[3] = 10'd639; by[3] = 9'd479;
    exp_addr[0] = 0; exp_addr[1] = 1; exp_addr[2] = 640; exp_addr[3] = 307199;

    step(); step(); step();
    chk("rst_busy",    0, int'(busy), 0);
    chk("rst_we",      0, int'(disp_we), 0);
    chk("rst_clear",   0, int'(disp_clear), 0);
    chk("rst_addr",    0, int'(disp_addr), 0);
    chk("rst_done",    0, int'(frame_done), 0);
    chk("rst_overrun", 0, int'(overrun), 0);
    chk("rst_sel",     0, int'(boid_sel), 0);
    reset = 1'b0;

    // No strobe: stays idle
    idle_check(6, 1'b0);

    // Frame with a mid-frame strobe at N+4 -> pending, no overrun,
    // second frame follows back-to-back (clear at N+12).
    screen_end = 1'b1;
    run_frame(4, 0, 4'b1111, 1'b0);
    run_frame(0, 0, 4'b1111, 1'b0);
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
    chk("skip_zero", 0, int'(skip_count), 0);
`endif
    idle_check(4, 1'b0);

    // Strobe coincident with DONE is kept
    screen_end = 1'b1;
    run_frame(10, 0, 4'b1111, 1'b0);
    run_frame(0, 0, 4'b1111, 1'b0);
    idle_check(4, 1'b0);

    // Off-screen boid 2 at (700,10): 10*640+700 = 7100
    bx[2] = 10'd700; by[2] = 9'd10;
    exp_addr[2] = 7100;
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
    mask_b = 4'b1011;
`else
    mask_b = 4'b1111;
`endif
    screen_end = 1'b1;
    run_frame(0, 0, mask_b, 1'b0);
`ifdef BOID_SCHED_BOUNDS_CHECK_EN
    chk("skip_one", 0, int'(skip_count), 1);
`endif
    bx[2] = 10'd0; by[2] = 9'd1;
    exp_addr[2] = 640;
    idle_check(3, 1'b0);

    // Two strobes in one busy frame -> overrun, exactly one extra frame
    screen_end = 1'b1;
    run_frame(3, 6, 4'b1111, 1'b1);
    run_frame(0, 0, 4'b1111, 1'b1);
    idle_check(5, 1'b1);

    // Reset in the cycle of the second write
    screen_end = 1'b1;
    step();
    screen_end = 1'b0;
    step(); step(); step(); step();
    chk("mid_we",   5, int'(disp_we), 1);
    chk("mid_addr", 5, int'(disp_addr), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy",    6, int'(busy), 0);
    chk("mr_we",      6, int'(disp_we), 0);
    chk("mr_sel",     6, int'(boid_sel), 0);
    chk("mr_overrun", 6, int'(overrun), 0);
    chk("mr_addr",    6, int'(disp_addr), 0);
    writes = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (disp_we || disp_clear) writes++;
    end
    chk("mr_no_writes", 0, writes, 0);

    // Normal operation after reset recovery
    screen_end = 1'b1;
    run_frame(0, 0, 4'b1111, 1'b0);
    idle_check(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
